// File: rtl/subleq_pkg.sv
// Shared encodings for the subleq execution controller.
package subleq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RA,
    ST_RB,
    ST_RC,
    ST_RDA,
    ST_RDB,
    ST_EX,
    ST_WB,
    ST_HALT
  } state_e;

  localparam int SUBLEQ_LEN = 3;

endpackage

// File: rtl/subleq_alu.sv
// Combinational subtract-and-test: res = vb - va, leq flags signed res <= 0.
module subleq_alu #(
  parameter int P_DATA = 8
) (
  input  logic [P_DATA-1:0] va_i,
  input  logic [P_DATA-1:0] vb_i,
  output logic [P_DATA-1:0] res_o,
  output logic              leq_o
);

  // Wraps mod 2^P_DATA; overflow is deliberately not folded into the sign test.
  assign res_o = vb_i - va_i;
  assign leq_o = (res_o == '0) | res_o[P_DATA-1];

endmodule

// File: rtl/subleq_core.sv
// Subleq controller: fetches A/B/C, reads mem[A]/mem[B], writes mem[B]-mem[A], branches on <=0.
module subleq_core
  import subleq_pkg::*;
#(
  parameter int P_ADDR = 8,
  parameter int P_DATA = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rw,
  output logic [P_ADDR-1:0] mem_addr,
  output logic [P_DATA-1:0] mem_din,
  input  logic [P_DATA-1:0] mem_dout,
  output logic              busy,
  output logic              halted,
  output logic [P_ADDR-1:0] pc
);

  state_e            state_q, state_d;
  logic [P_ADDR-1:0] pc_q, pc_d;
  logic [P_ADDR-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [P_DATA-1:0] va_q, va_d, vb_q, vb_d;
  logic [P_DATA-1:0] res;
  logic              leq;
  logic [P_ADDR-1:0] dout_addr;

  generate
    if (P_DATA >= P_ADDR) begin : g_addr_trunc
      assign dout_addr = mem_dout[P_ADDR-1:0];
    end else begin : g_addr_zext
      assign dout_addr = {{(P_ADDR - P_DATA){1'b0}}, mem_dout};
    end
  endgenerate

  subleq_alu #(.P_DATA(P_DATA)) u_alu (
    .va_i  (va_q),
    .vb_i  (vb_q),
    .res_o (res),
    .leq_o (leq)
  );

  // NOTE: sequential state uses <= so every register samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      va_q    <= '0;
      vb_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
    end
  end

  // NOTE: every output and _d gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    va_d     = va_q;
    vb_d     = vb_q;
    mem_rw   = 1'b0;
    mem_addr = pc_q;
    mem_din  = '0;
    busy     = 1'b1;
    halted   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_RA;
      end
      ST_RA: state_d = ST_RB;
      ST_RB: begin
        mem_addr = pc_q + P_ADDR'(1);
        ra_d     = dout_addr;
        state_d  = ST_RC;
      end
      ST_RC: begin
        mem_addr = pc_q + P_ADDR'(2);
        rb_d     = dout_addr;
        state_d  = ST_RDA;
      end
      ST_RDA: begin
        mem_addr = ra_q;
        rc_d     = dout_addr;
        state_d  = ST_RDB;
      end
      ST_RDB: begin
        mem_addr = rb_q;
        va_d     = mem_dout;
        state_d  = ST_EX;
      end
      ST_EX: begin
        mem_addr = rb_q;
        vb_d     = mem_dout;
        state_d  = ST_WB;
      end
      ST_WB: begin
        // Gated by rst so a reset landing on WB drops the write instead of committing it.
        mem_rw   = ~rst;
        mem_addr = rb_q;
        mem_din  = res;
        if (leq && (rc_q == pc_q)) begin
          state_d = ST_HALT;
        end else if (leq) begin
          pc_d    = rc_q;
          state_d = ST_RA;
        end else begin
          pc_d    = pc_q + P_ADDR'(SUBLEQ_LEN);
          state_d = ST_RA;
        end
      end
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_subleq_core.sv
// Directed bench for subleq_core with a behavioural 1-cycle-read RAM and a preload port.
module tb_subleq_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mem_rw;
  logic [7:0] mem_addr, mem_din, mem_dout, pc;
  logic       busy, halted;

  logic [7:0] ram [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = '0, pl_data = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (mem_rw) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  subleq_core #(.P_ADDR(8), .P_DATA(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy),
    .halted   (halted),
    .pc       (pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic load_instr(input logic [7:0] base, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
    poke(base, a);
    poke(base + 8'd1, b);
    poke(base + 8'd2, c);
  endtask

  // Entry: core in RA. Checks the 7 states RA..WB and leaves the core one cycle past WB.
  task automatic run_instr(input string tag, input logic [7:0] pc0, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_res);
    logic [7:0] exp_addr [7];
    exp_addr = '{pc0, pc0 + 8'd1, pc0 + 8'd2, a, b, b, b};
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s addr[%0d]", tag, k), mem_addr, exp_addr[k]);
      check($sformatf("%s rw[%0d]", tag, k), mem_rw, (k == 6));
      check($sformatf("%s din[%0d]", tag, k), mem_din, (k == 6) ? exp_res : 8'h00);
      check($sformatf("%s busy[%0d]", tag, k), busy, 1'b1);
      tick();
    end
  endtask

  task automatic reset_and_start();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic [7:0] c;
    logic [7:0] exp_b;
    logic [7:0] exp_pc;
    logic       exp_halt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int rw_seen;

    vecs[0] = '{8'd2,  8'd5,  8'd3,  8'd3,  8'd3,  1'b0};  // not taken
    vecs[1] = '{8'd5,  8'd5,  8'd9,  8'd0,  8'd9,  1'b0};  // taken on zero
    vecs[2] = '{8'd1,  8'd0,  8'd20, 8'hFF, 8'd20, 1'b0};  // taken on negative
    vecs[3] = '{8'd1,  8'h80, 8'd20, 8'h7F, 8'd3,  1'b0};  // signed wrap, not taken
    vecs[4] = '{8'hFF, 8'h7F, 8'd30, 8'h80, 8'd30, 1'b0};  // 127-(-1) wraps negative
    vecs[5] = '{8'd3,  8'd1,  8'd0,  8'hFE, 8'd0,  1'b1};  // taken onto itself -> halt

    // Reset state
    tick();
    tick();
    check("rst rw", mem_rw, 1'b0);
    check("rst addr", mem_addr, 8'h00);
    check("rst din", mem_din, 8'h00);
    check("rst pc", pc, 8'h00);
    check("rst busy", busy, 1'b0);
    check("rst halted", halted, 1'b0);
    rst = 1'b0;
    #1;
    check("idle busy", busy, 1'b0);

    // Table-driven single instructions at pc=0: A=10, B=11
    for (int v = 0; v < 6; v++) begin
      rst = 1'b1;
      load_instr(8'd0, 8'd10, 8'd11, vecs[v].c);
      poke(8'd10, vecs[v].a_val);
      poke(8'd11, vecs[v].b_val);
      reset_and_start();
      run_instr($sformatf("v%0d", v), 8'd0, 8'd10, 8'd11, vecs[v].exp_b);
      check($sformatf("v%0d mem11", v), ram[11], vecs[v].exp_b);
      check($sformatf("v%0d pc", v), pc, vecs[v].exp_pc);
      check($sformatf("v%0d halted", v), halted, vecs[v].exp_halt);
      check($sformatf("v%0d busy", v), busy, !vecs[v].exp_halt);
    end

    // Halt is sticky: no writes, start ignored
    rst = 1'b1;
    load_instr(8'd0, 8'd12, 8'd12, 8'd0);
    poke(8'd12, 8'd7);
    reset_and_start();
    run_instr("halt", 8'd0, 8'd12, 8'd12, 8'd0);
    check("halt mem12", ram[12], 8'd0);
    check("halt halted", halted, 1'b1);
    check("halt busy", busy, 1'b0);
    rw_seen = 0;
    for (int k = 0; k < 20; k++) begin
      start = (k % 3 == 0);
      if (mem_rw) rw_seen++;
      tick();
    end
    start = 1'b0;
    check("halt rw count", rw_seen, 0);
    check("halt sticky", halted, 1'b1);
    check("halt pc", pc, 8'd0);

    // Wrap: jump to 0xFE, then instruction at FE,FF,00 falls through to 0x01
    rst = 1'b1;
    load_instr(8'd0, 8'd10, 8'd11, 8'hFE);
    poke(8'd10, 8'd1);
    poke(8'd11, 8'd0);
    poke(8'hFE, 8'h20);
    poke(8'hFF, 8'h21);
    poke(8'h20, 8'd1);
    poke(8'h21, 8'd5);
    reset_and_start();
    run_instr("wrap0", 8'd0, 8'd10, 8'd11, 8'hFF);
    check("wrap0 pc", pc, 8'hFE);
    run_instr("wrap1", 8'hFE, 8'h20, 8'h21, 8'd4);
    check("wrap1 mem21", ram[8'h21], 8'd4);
    check("wrap1 pc", pc, 8'h01);

    // Reset during RDB: pending write never issued
    rst = 1'b1;
    load_instr(8'd0, 8'd10, 8'd11, 8'd3);
    poke(8'd10, 8'd2);
    poke(8'd11, 8'd5);
    reset_and_start();
    rw_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (mem_rw) rw_seen++;
      tick();
    end
    check("rdb addr", mem_addr, 8'd11);
    rst = 1'b1;
    tick();
    check("rdb rst busy", busy, 1'b0);
    check("rdb rst pc", pc, 8'd0);
    check("rdb rst addr", mem_addr, 8'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (mem_rw) rw_seen++;
      tick();
    end
    check("rdb rw count", rw_seen, 0);
    check("rdb mem11", ram[11], 8'd5);
    check("rdb idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
